// File: rtl/irrigation_controller_if.sv
// Sensor, request and valve/display bundle between the field side and the irrigation controller.
`timescale 1ns/1ps
interface irrigation_controller_if;
    logic       tick_1s;
    logic       H;
    logic       M;
    logic       L;
    logic       req_asp;
    logic       req_got;
    logic       Bs;
    logic       Vs;
    logic       Ve;
    logic       Error;
    logic [3:0] bcd;
    logic [3:0] bcd_10s;
    logic       done;

    // master drives sensors and requests; slave is the controller
    modport master (
        output tick_1s, H, M, L, req_asp, req_got,
        input  Bs, Vs, Ve, Error, bcd, bcd_10s, done
    );
    modport slave (
        input  tick_1s, H, M, L, req_asp, req_got,
        output Bs, Vs, Ve, Error, bcd, bcd_10s, done
    );
endinterface

// File: rtl/irrigation_controller.sv
// Tank-fed sprinkler/drip sequencer with BCD countdown; all outputs registered, one-edge response.
// No backpressure. ERROR_LATCH_EN makes the sensor-fault state sticky until reset.
`timescale 1ns/1ps
module irrigation_controller #(
    parameter int ASP_TIME = 25,
    parameter int GOT_TIME = 50
) (
    input  logic                   clock,
    input  logic                   rst_n,
    irrigation_controller_if.slave bus
);
    typedef enum logic [2:0] {IDLE, FILL, ASP, GOT, ERR} state_t;

    localparam logic [3:0] ASP_TENS  = 4'(ASP_TIME / 10);
    localparam logic [3:0] ASP_UNITS = 4'(ASP_TIME % 10);
    localparam logic [3:0] GOT_TENS  = 4'(GOT_TIME / 10);
    localparam logic [3:0] GOT_UNITS = 4'(GOT_TIME % 10);

    state_t     state;
    logic       bs, vs, ve, err, done_r;
    logic [3:0] units, tens;
    logic       fault;

    // a higher sensor wet while a lower one is dry is physically impossible
    assign fault = (bus.H & ~bus.M) | (bus.M & ~bus.L);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            bs     <= 1'b0;
            vs     <= 1'b0;
            ve     <= 1'b0;
            err    <= 1'b0;
            done_r <= 1'b0;
            units  <= 4'd0;
            tens   <= 4'd0;
        end else begin
            done_r <= 1'b0;
            if (fault) begin
                state <= ERR;
                bs    <= 1'b0;
                vs    <= 1'b0;
                ve    <= 1'b0;
                err   <= 1'b1;
                units <= 4'd0;
                tens  <= 4'd0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (!bus.L) begin
                            state <= FILL;
                            ve    <= 1'b1;
                        end else if (bus.req_asp) begin
                            state <= ASP;
                            bs    <= 1'b1;
                            tens  <= ASP_TENS;
                            units <= ASP_UNITS;
                        end else if (bus.req_got) begin
                            state <= GOT;
                            vs    <= 1'b1;
                            tens  <= GOT_TENS;
                            units <= GOT_UNITS;
                        end
                    end
                    FILL: begin
                        if (bus.H) begin
                            state <= IDLE;
                            ve    <= 1'b0;
                        end
                    end
                    ASP, GOT: begin
                        // running dry outranks the tick; remaining time is dropped
                        if (!bus.L) begin
                            state <= FILL;
                            bs    <= 1'b0;
                            vs    <= 1'b0;
                            ve    <= 1'b1;
                            units <= 4'd0;
                            tens  <= 4'd0;
                        end else if (bus.tick_1s) begin
                            if (tens == 4'd0 && units == 4'd1) begin
                                state  <= IDLE;
                                bs     <= 1'b0;
                                vs     <= 1'b0;
                                done_r <= 1'b1;
                                units  <= 4'd0;
                            end else if (units == 4'd0) begin
                                units <= 4'd9;
                                tens  <= tens - 4'd1;
                            end else begin
                                units <= units - 4'd1;
                            end
                        end
                    end
                    ERR: begin
`ifdef ERROR_LATCH_EN
                        state <= ERR;
`else
                        state <= IDLE;
                        err   <= 1'b0;
`endif
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.Bs      = bs;
    assign bus.Vs      = vs;
    assign bus.Ve      = ve;
    assign bus.Error   = err;
    assign bus.done    = done_r;
    assign bus.bcd     = units;
    assign bus.bcd_10s = tens;
endmodule

// File: tb/tb_irrigation_controller.sv
// Directed scenarios plus randomized sensor/request/tick traffic checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_irrigation_controller;
    localparam int ASP_T = 25;
    localparam int GOT_T = 50;
    localparam int MI = 0, MF = 1, MA = 2, MG = 3, ME = 4;

    logic clock = 1'b0;
    logic rst_n = 1'b0;

    irrigation_controller_if ifc();

    irrigation_controller #(.ASP_TIME(ASP_T), .GOT_TIME(GOT_T)) dut (
        .clock(clock),
        .rst_n(rst_n),
        .bus  (ifc.slave)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_err    = 0;
    bit cmp_en   = 1'b0;
    int done_seen = 0;

    // model: mode plus integer seconds remaining
    int m_mode = MI;
    int m_rem  = 0;
    bit m_done = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cnt();
        return int'({ifc.bcd_10s, ifc.bcd});
    endfunction

    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = MI;
            m_rem  = 0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if ((ifc.H && !ifc.M) || (ifc.M && !ifc.L)) begin
                m_mode = ME;
                m_rem  = 0;
            end else if (m_mode == MI) begin
                if (!ifc.L)             m_mode = MF;
                else if (ifc.req_asp) begin m_mode = MA; m_rem = ASP_T; end
                else if (ifc.req_got) begin m_mode = MG; m_rem = GOT_T; end
            end else if (m_mode == MF) begin
                if (ifc.H) m_mode = MI;
            end else if (m_mode == MA || m_mode == MG) begin
                if (!ifc.L) begin
                    m_mode = MF;
                    m_rem  = 0;
                end else if (ifc.tick_1s) begin
                    m_rem = m_rem - 1;
                    if (m_rem == 0) begin
                        m_mode = MI;
                        m_done = 1'b1;
                    end
                end
            end else begin
`ifdef ERROR_LATCH_EN
                m_mode = ME;
`else
                m_mode = MI;
`endif
            end
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            chk("Bs",      int'(ifc.Bs),    int'(m_mode == MA));
            chk("Vs",      int'(ifc.Vs),    int'(m_mode == MG));
            chk("Ve",      int'(ifc.Ve),    int'(m_mode == MF));
            chk("Error",   int'(ifc.Error), int'(m_mode == ME));
            chk("done",    int'(ifc.done),  int'(m_done));
            chk("bcd",     int'(ifc.bcd),     m_rem % 10);
            chk("bcd_10s", int'(ifc.bcd_10s), m_rem / 10);
            if (m_done) done_seen++;
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic ticks(input int n);
        ifc.tick_1s = 1'b1;
        repeat (n) step();
        ifc.tick_1s = 1'b0;
    endtask

    task automatic set_lvl(input int lv);
        ifc.L = (lv >= 1);
        ifc.M = (lv >= 2);
        ifc.H = (lv >= 3);
    endtask

    initial begin
        int r;
        ifc.tick_1s = 1'b0;
        ifc.req_asp = 1'b0;
        ifc.req_got = 1'b0;
        set_lvl(0);
        rst_n = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        chk("rst_Bs", int'(ifc.Bs), 0);
        chk("rst_Ve", int'(ifc.Ve), 0);
        chk("rst_Error", int'(ifc.Error), 0);
        chk("rst_count", cnt(), 0);
        cmp_en = 1'b1;
        rst_n = 1'b1;

        // sprinkler run of exactly ASP_T ticks; request dropped mid-run
        set_lvl(3);
        ifc.req_asp = 1'b1;
        step();
        chk("asp_start_Bs", int'(ifc.Bs), 1);
        chk("asp_load", cnt(), 'h25);
        ifc.req_asp = 1'b0;
        ticks(24);
        chk("asp_at_01", cnt(), 'h01);
        chk("asp_still_on", int'(ifc.Bs), 1);
        ticks(1);
        chk("asp_done", int'(ifc.done), 1);
        chk("asp_end_count", cnt(), 0);
        chk("asp_end_Bs", int'(ifc.Bs), 0);
        step();
        chk("done_one_cycle", int'(ifc.done), 0);

        // both requests: sprinkler first, then drip
        ifc.req_asp = 1'b1;
        ifc.req_got = 1'b1;
        step();
        chk("prio_Bs", int'(ifc.Bs), 1);
        chk("prio_Vs", int'(ifc.Vs), 0);
        ifc.req_asp = 1'b0;
        ticks(25);
        chk("prio_asp_done", int'(ifc.done), 1);
        step();
        chk("got_Vs", int'(ifc.Vs), 1);
        chk("got_load", cnt(), 'h50);
        ticks(1);
        chk("got_49", cnt(), 'h49);
        ticks(19);
        chk("got_30", cnt(), 'h30);
        ifc.req_got = 1'b0;

        // tank runs dry during drip
        set_lvl(0);
        step();
        chk("dry_Ve", int'(ifc.Ve), 1);
        chk("dry_Vs", int'(ifc.Vs), 0);
        chk("dry_count", cnt(), 0);
        chk("dry_no_done", int'(ifc.done), 0);
        set_lvl(3);
        step();
        chk("filled_Ve", int'(ifc.Ve), 0);

        // tens borrow on a fresh drip run
        ifc.req_got = 1'b1;
        step();
        ifc.req_got = 1'b0;
        ticks(40);
        chk("got_10", cnt(), 'h10);
        ticks(1);
        chk("got_09", cnt(), 'h09);
        ticks(9);
        chk("got_done", int'(ifc.done), 1);

        // sensor fault during sprinkler run
        ifc.req_asp = 1'b1;
        step();
        ifc.req_asp = 1'b0;
        ticks(3);
        ifc.H = 1'b1; ifc.M = 1'b0; ifc.L = 1'b1;
        step();
        chk("fault_Error", int'(ifc.Error), 1);
        chk("fault_Bs", int'(ifc.Bs), 0);
        chk("fault_count", cnt(), 0);
        set_lvl(3);
        step();
`ifdef ERROR_LATCH_EN
        chk("fault_sticky", int'(ifc.Error), 1);
`else
        chk("fault_cleared", int'(ifc.Error), 0);
`endif
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("fault_reset", int'(ifc.Error), 0);

        // asynchronous reset mid-run
        ifc.req_asp = 1'b1;
        step();
        ifc.req_asp = 1'b0;
        ticks(13);
        chk("asp_12", cnt(), 'h12);
        rst_n = 1'b0;
        #1;
        chk("async_Bs", int'(ifc.Bs), 0);
        chk("async_count", cnt(), 0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_Bs", int'(ifc.Bs), 0);
        chk("post_rst_count", cnt(), 0);

        // last tick coincident with dry tank
        ifc.req_asp = 1'b1;
        step();
        ifc.req_asp = 1'b0;
        ticks(24);
        chk("edge_01", cnt(), 'h01);
        ifc.tick_1s = 1'b1;
        set_lvl(0);
        step();
        ifc.tick_1s = 1'b0;
        chk("edge_Ve", int'(ifc.Ve), 1);
        chk("edge_no_done", int'(ifc.done), 0);
        chk("edge_count", cnt(), 0);
        set_lvl(3);
        step();

        // randomized traffic
        done_seen = 0;
        for (int i = 0; i < 6000; i++) begin
            ifc.tick_1s = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 39) == 0) begin
                r = $urandom_range(0, 19);
                if (r == 0) begin
                    case ($urandom_range(0, 3))
                        0:       {ifc.H, ifc.M, ifc.L} = 3'b100;
                        1:       {ifc.H, ifc.M, ifc.L} = 3'b101;
                        2:       {ifc.H, ifc.M, ifc.L} = 3'b010;
                        default: {ifc.H, ifc.M, ifc.L} = 3'b110;
                    endcase
                end else if (r < 12) begin
                    set_lvl(3);
                end else begin
                    set_lvl($urandom_range(0, 2));
                end
            end
            if ($urandom_range(0, 29) == 0) ifc.req_asp = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 29) == 0) ifc.req_got = 1'($urandom_range(0, 1));
            rst_n = ($urandom_range(0, 799) != 0);
            step();
        end
        rst_n = 1'b1;
        step();
        chk("random_runs_completed", int'(done_seen > 0), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
